// File: rtl/pacc_pkg.sv
// Shared constants for the polynomial subtract/reduce datapath: Kyber defaults,
// the sequencer state encoding and the Barrett reduction constant.
package pacc_pkg;

  localparam int unsigned PACC_KYBER_N = 256;
  localparam int unsigned PACC_KYBER_Q = 3329;
  localparam int unsigned PACC_COEFF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SUB   = 2'd2,
    ST_DRAIN = 2'd3
  } psub_state_e;

  // Shift of 24 keeps the Barrett quotient error below one for the
  // 18-bit offset difference, so a single conditional subtract is exact.
  localparam int unsigned BARRETT_K = 24;

  function automatic int unsigned barrett_m(input int unsigned q);
    return (32'd1 << BARRETT_K) / q;
  endfunction

  localparam int unsigned BARRETT_M = barrett_m(PACC_KYBER_Q);

endpackage

// File: rtl/poly_sub_reduce.sv
// One registered stage: signed 17-bit a-b, exact mod-q reduction via Barrett.
// POLY_SUB_CANONICAL_EN selects [0,q-1] output; default is the centered form.
module poly_sub_reduce
  import pacc_pkg::*;
#(
  parameter int unsigned KYBER_Q = PACC_KYBER_Q,
  parameter int unsigned COEFF_W = PACC_COEFF_W,
  parameter int unsigned IDX_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               valid_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [COEFF_W-1:0] a_i,
  input  logic [COEFF_W-1:0] b_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [COEFF_W-1:0] r_o
);

  localparam int unsigned X_W    = COEFF_W + 2;
  localparam int unsigned P_W    = X_W + BARRETT_K;
  localparam int unsigned OFS    = (((1 << COEFF_W) - 1 + KYBER_Q - 1) / KYBER_Q) * KYBER_Q;
  localparam int unsigned BM     = barrett_m(KYBER_Q);
  localparam int unsigned HALF_Q = (KYBER_Q - 1) / 2;

  logic signed [COEFF_W:0] diff;
  logic [X_W-1:0]          x;
  logic [P_W-1:0]          prod;
  logic [X_W-1:0]          qe;
  logic [X_W-1:0]          rem0;
  logic [X_W-1:0]          rem;
  logic [COEFF_W-1:0]      r_d, r_q;
  logic                    valid_q;
  logic [IDX_W-1:0]        idx_q;

  always_comb begin
    diff = $signed({a_i[COEFF_W-1], a_i}) - $signed({b_i[COEFF_W-1], b_i});
    // Adding a multiple of q lifts the difference into a non-negative range
    // without changing its residue.
    x    = {{(X_W-COEFF_W-1){diff[COEFF_W]}}, diff} + X_W'(OFS);
    prod = P_W'(x) * P_W'(BM);
    qe   = X_W'(prod >> BARRETT_K);
    rem0 = x - X_W'(qe * KYBER_Q);
    rem  = (rem0 >= X_W'(KYBER_Q)) ? rem0 - X_W'(KYBER_Q) : rem0;
`ifdef POLY_SUB_CANONICAL_EN
    r_d  = COEFF_W'(rem);
`else
    r_d  = (rem > X_W'(HALF_Q)) ? COEFF_W'(rem) - COEFF_W'(KYBER_Q) : COEFF_W'(rem);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      r_q     <= '0;
    end else begin
      valid_q <= valid_i;
      idx_q   <= idx_i;
      r_q     <= r_d;
    end
  end

  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign r_o     = r_q;

endmodule

// File: rtl/poly_sub_modq.sv
// Coefficient-serial polynomial subtract mod q: sequencer, index counter and
// oPoly writeback. POLY_SUB_CANONICAL_EN (in poly_sub_reduce) picks output range.
module poly_sub_modq
  import pacc_pkg::*;
#(
  parameter int unsigned KYBER_N = PACC_KYBER_N,
  parameter int unsigned KYBER_Q = PACC_KYBER_Q,
  parameter int unsigned COEFF_W = PACC_COEFF_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [COEFF_W*KYBER_N-1:0] iPoly_a,
  input  logic [COEFF_W*KYBER_N-1:0] iPoly_b,
  output logic [COEFF_W*KYBER_N-1:0] oPoly,
  output logic                       Poly_Sub_done
);

  localparam int unsigned IDX_W = (KYBER_N > 1) ? $clog2(KYBER_N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KYBER_N - 1);

  psub_state_e state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       issue;
  logic [COEFF_W-1:0]         a_sel, b_sel;
  logic                       red_valid;
  logic [IDX_W-1:0]           red_idx;
  logic [COEFF_W-1:0]         red_r;
  logic [COEFF_W*KYBER_N-1:0] poly_q;
  logic                       last_wb_q, last_wb_d;
  logic                       done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_SUB;
        idx_d   = '0;
      end
      ST_SUB: begin
        issue = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_sel = iPoly_a[(KYBER_N - 1 - 32'(idx_q)) * COEFF_W +: COEFF_W];
    b_sel = iPoly_b[(KYBER_N - 1 - 32'(idx_q)) * COEFF_W +: COEFF_W];
  end

  poly_sub_reduce #(
    .KYBER_Q (KYBER_Q),
    .COEFF_W (COEFF_W),
    .IDX_W   (IDX_W)
  ) u_reduce (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (issue),
    .idx_i   (idx_q),
    .a_i     (a_sel),
    .b_i     (b_sel),
    .valid_o (red_valid),
    .idx_o   (red_idx),
    .r_o     (red_r)
  );

  // Done trails the final writeback by a cycle so oPoly is settled when it rises.
  always_comb begin
    last_wb_d = red_valid && (red_idx == IDX_LAST);
    done_d    = last_wb_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_wb_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_wb_q <= last_wb_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poly_q <= '0;
    end else if (red_valid) begin
      poly_q[(KYBER_N - 1 - 32'(red_idx)) * COEFF_W +: COEFF_W] <= red_r;
    end
  end

  assign oPoly         = poly_q;
  assign Poly_Sub_done = done_q;

endmodule

// File: tb/tb_poly_sub_modq.sv
// Bench for poly_sub_modq: edge-timed reference model plus directed literal checks.
module tb_poly_sub_modq;

  localparam int N    = 256;
  localparam int Q    = 3329;
  localparam int W    = 16;
  localparam int VW   = N * W;
  localparam int RUNS = 250;

`ifdef POLY_SUB_CANONICAL_EN
  localparam logic [W-1:0] EXP_M1   = 16'h0D00;
  localparam logic [W-1:0] EXP_3328 = 16'd3328;
  localparam logic [W-1:0] EXP_MAXD = 16'd2284;
`else
  localparam logic [W-1:0] EXP_M1   = 16'hFFFF;
  localparam logic [W-1:0] EXP_3328 = 16'hFFFF;
  localparam logic [W-1:0] EXP_MAXD = 16'hFBEB;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [VW-1:0] a, b, o;
  logic          done;

  int n_tests   = 0;
  int n_fail    = 0;
  bit chk_on    = 1'b0;
  bit sweep_on  = 1'b0;
  int done_seen = 0;

  always #5 clk = ~clk;

  poly_sub_modq #(
    .KYBER_N (N),
    .KYBER_Q (Q),
    .COEFF_W (W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .iPoly_a       (a),
    .iPoly_b       (b),
    .oPoly         (o),
    .Poly_Sub_done (done)
  );

  function automatic logic [W-1:0] coef(input logic [VW-1:0] v, input int k);
    return v[(N-1-k)*W +: W];
  endfunction

  function automatic logic [W-1:0] ref_red(input logic [W-1:0] x, input logic [W-1:0] y);
    int d;
    int r;
    d = int'($signed(x)) - int'($signed(y));
    r = d % Q;
    if (r < 0) r += Q;
`ifndef POLY_SUB_CANONICAL_EN
    if (r > (Q-1)/2) r -= Q;
`endif
    return W'(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_coef(input bit is_b, input int k, input logic [W-1:0] v);
    if (is_b) b[(N-1-k)*W +: W] = v;
    else      a[(N-1-k)*W +: W] = v;
  endtask

  task automatic randomize_polys();
    for (int k = 0; k < N; k++) begin
      for (int s = 0; s < 2; s++) begin
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
          0:       v = 16'h8000;
          1:       v = 16'h7FFF;
          default: v = W'($urandom);
        endcase
        set_coef(s[0], k, v);
      end
    end
  endtask

  // Reference model: each accepted start at edge s writes coefficient k at
  // edge s+k+3 and pulses done at s+N+3; the next start is accepted from s+N+3.
  int           edge_n     = 0;
  int           starts[$];
  int           busy_until = 0;
  logic         exp_done   = 1'b0;
  logic [W-1:0] exp_c [N];

  initial for (int k = 0; k < N; k++) exp_c[k] = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starts.delete();
      busy_until = 0;
      exp_done   = 1'b0;
      for (int k = 0; k < N; k++) exp_c[k] = '0;
    end else begin
      edge_n++;
      exp_done = 1'b0;
      foreach (starts[i]) begin
        int k;
        k = edge_n - starts[i] - 3;
        if (k >= 0 && k < N) exp_c[k] = ref_red(coef(a, k), coef(b, k));
        if (edge_n == starts[i] + N + 3) exp_done = 1'b1;
      end
      while (starts.size() > 0 && edge_n >= starts[0] + N + 3) void'(starts.pop_front());
      if (enable && edge_n >= busy_until) begin
        starts.push_back(edge_n);
        busy_until = edge_n + N + 3;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int bad;
      bad = -1;
      n_tests++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL done_cycle t=%0t: actual=%0b expected=%0b", $time, done, exp_done);
      end
      for (int k = 0; k < N; k++) begin
        if (o[(N-1-k)*W +: W] !== exp_c[k]) begin
          bad = k;
          break;
        end
      end
      n_tests++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL opoly_coef t=%0t k=%0d: actual=0x%0h expected=0x%0h",
                 $time, bad, o[(N-1-bad)*W +: W], exp_c[bad]);
      end
      if (sweep_on && done) done_seen++;
    end
  end

  // Pulse enable once; return the edge count (after the sampling edge) at which done rose.
  task automatic do_run(input bit repulse, output int dedge);
    enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    dedge = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (repulse && c == 100) enable = 1'b1;
      if (repulse && c == 101) enable = 1'b0;
      if (done) begin
        dedge = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    int de;
    int nbad;
    reset_n = 1'b0;
    enable  = 1'b0;
    a       = '0;
    b       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_opoly_zero", {31'b0, |o}, 32'd0);
    chk("reset_done_low", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_on  = 1'b1;

    // Small values, q-1, and an ignored re-pulse during SUB
    set_coef(0, 0, 16'd5);
    set_coef(1, 0, 16'd3);
    set_coef(0, 1, 16'd3328);
    set_coef(1, 1, 16'd0);
    do_run(1'b1, de);
    chk("done_edge_A", de, N + 3);
    chk("r0_5_minus_3", 32'(coef(o, 0)), 32'd2);
    chk("r1_3328_minus_0", 32'(coef(o, 1)), 32'(EXP_3328));
    chk("r2_zero", 32'(coef(o, 2)), 32'd0);

    // 0 - 1 everywhere
    a = '0;
    for (int k = 0; k < N; k++) set_coef(1, k, 16'd1);
    do_run(1'b0, de);
    chk("done_edge_B", de, N + 3);
    nbad = 0;
    for (int k = 0; k < N; k++) if (coef(o, k) !== EXP_M1) nbad++;
    chk("all_minus_one_bad_count", nbad, 0);
    chk("c255_minus_one", 32'(coef(o, N-1)), 32'(EXP_M1));

    // Extreme differences
    a = '0;
    b = '0;
    set_coef(0, 0, 16'h8000);
    set_coef(1, 0, 16'h7FFF);
    set_coef(0, 1, 16'h7FFF);
    set_coef(1, 1, 16'h8000);
    do_run(1'b0, de);
    chk("done_edge_C", de, N + 3);
    chk("r0_min_minus_max", 32'(coef(o, 0)), 32'd1045);
    chk("r1_max_minus_min", 32'(coef(o, 1)), 32'(EXP_MAXD));
    chk("r2_rewritten_zero", 32'(coef(o, 2)), 32'd0);

    // Abort with index 100 in SUB, then a fresh run
    randomize_polys();
    enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (101) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_opoly_zero", {31'b0, |o}, 32'd0);
    chk("abort_done_low", {31'b0, done}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    randomize_polys();
    do_run(1'b0, de);
    chk("done_edge_after_abort", de, N + 3);

    // Back-to-back runs with enable held high
    done_seen = 0;
    sweep_on  = 1'b1;
    enable    = 1'b1;
    @(posedge clk);
    for (int r = 0; r < RUNS; r++) begin
      #2;
      randomize_polys();
      if (r == RUNS - 1) enable = 1'b0;
      repeat (N + 3) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    sweep_on = 1'b0;
    chk("sweep_done_count", done_seen, RUNS);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
